serial_frame_sender: RTL
========================

Name: serial_frame_sender

Overview:
Upstream stage of the serial port-demux system. It takes one parallel frame request (target port, bit count, payload) and serialises it onto the line that feeds the demux's ser_in input. It also generates the bit-step strobe that drives the demux's clkPB input. This replaces manual push-button stepping with a deterministic, self-timed transmitter.

Parameters:
TICK_DIV, 4, clk cycles per serial bit period; legal range is 2 or more, even values only
LEN_W, 4, width of the data-count field
DATA_W, 15, payload register width; equals 2**LEN_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk
start  input  1  frame request, sampled only while ready=1
port_sel  input  2  target port number, 0..3
data_len  input  LEN_W  number of payload bits to send, 0..15
payload  input  DATA_W  payload bits; bit data_len-1 is sent first
ready  output  1  idle and accepting start
ser_out  output  1  serial line; idles high
bit_strobe  output  1  step strobe; rising edge falls mid-bit
done  output  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, ser_out=1, bit_strobe=0, done=0, ready=1, all counters and shadow registers cleared. Reset overrides everything, including a frame in progress; the line returns high on the next cycle.
- FSM states: IDLE, START, PORT, COUNT, DATA, FINISH.
- IDLE: ser_out=1, ready=1.
  - On start=1, port_sel, data_len and payload are latched into shadow registers.
  - At the same edge the FSM moves to START and ready drops.
- Bit periods: every state other than IDLE and FINISH holds one bit for TICK_DIV cycles.
  - A tick counter runs 0..TICK_DIV-1 and restarts at each new bit.
  - bit_strobe=1 while tick >= TICK_DIV/2, otherwise 0.
  - ser_out changes only at tick 0, so it is stable for TICK_DIV/2 cycles before each strobe rising edge.
- START: sends one bit of value 0, then moves to PORT.
- PORT: sends port_sel[1] then port_sel[0], then moves to COUNT.
- COUNT: sends data_len MSB first (LEN_W bits).
  - If data_len=0, moves to FINISH.
  - Otherwise moves to DATA.
- DATA: sends payload[data_len-1] down to payload[0]. A bit index counter decrements once per bit period. After index 0 the FSM moves to FINISH.
- FINISH: lasts exactly one cycle. ser_out=1, done=1, ready=1. Next state is IDLE.
  - If start=1 in this cycle, the request is accepted exactly as in IDLE and the FSM goes straight to START (back-to-back frames).
- Frame length: 1+2+LEN_W+data_len bit periods.
- Latency: with start sampled at edge k, the start bit appears after edge k, and done is high in the cycle after the final bit period, i.e. after (7+data_len)*TICK_DIV cycles of line activity.
- start=1 while busy (ready=0) is ignored and not queued. Input changes while busy do not affect the frame in flight.
- Payload bits above data_len-1 are don't-care and never transmitted.
- bit_strobe is 0 in IDLE and FINISH. Exactly one strobe rising edge occurs per transmitted bit.

Test Plan:
- TICK_DIV=4; start with port_sel=2, data_len=3, payload=0b101 -> ser_out bits 0,1,0,0,0,1,1,1,0,1 (sampled at strobe rising edges), 10 strobe pulses, done 40 cycles after the start bit begins, then ser_out=1 and ready=1.
- data_len=0, port_sel=3 -> bits 0,1,1,0,0,0,0, 7 strobes, no DATA state, done after 28 cycles.
- data_len=15, payload=0x5A5A -> 22 bits total; the 15 data bits equal payload[14:0] MSB first.
- start pulsed mid-frame with different inputs -> the current frame is unchanged and no second frame is sent.
- start held high through the done cycle -> the second frame's start bit follows done with no idle cycle, and it carries the inputs present in the done cycle.
- rst=0 asserted during DATA -> next cycle ser_out=1, ready=1, bit_strobe=0, done never pulses; a new start afterwards produces a complete, correct frame.

Source files
------------

// File: rtl/serial_frame_sender.sv
// serial_frame_sender: serialises one frame (start bit, 2-bit port, length
// field, payload MSB first) onto ser_out and produces a mid-bit step strobe
// for the downstream demux. Each bit is held for TICK_DIV clock cycles.
module serial_frame_sender #(
  parameter int TICK_DIV = 4,
  parameter int LEN_W    = 4,
  parameter int DATA_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        port_sel,
  input  logic [LEN_W-1:0]  data_len,
  input  logic [DATA_W-1:0] payload,
  output logic              ready,
  output logic              ser_out,
  output logic              bit_strobe,
  output logic              done
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_DIV / 2);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [LEN_W-1:0]  IDX_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]  IDX_MSB   = LEN_W'(LEN_W - 1);
  localparam logic [DATA_W-1:0] PAY_ONE   = DATA_W'(1);

  typedef enum logic [2:0] {IDLE, START, PORT, COUNT, DATA, FINISH} state_t;

  state_t              state;
  state_t              next_state;
  logic [TICK_W-1:0]   tick;
  logic [LEN_W-1:0]    bit_idx;
  logic [1:0]          port_r;
  logic [LEN_W-1:0]    len_r;
  logic [DATA_W-1:0]   payload_r;
  logic                busy;
  logic                bit_end;
  logic                accept;
  logic                idx_zero;
  logic [LEN_W-1:0]    len_mask;
  logic [DATA_W-1:0]   pay_mask;

  // Shared decode: bit-period activity, end of a bit, and request acceptance
  always_comb begin
    busy     = (state != IDLE) && (state != FINISH);
    bit_end  = busy && (tick == TICK_LAST);
    accept   = start && ((state == IDLE) || (state == FINISH));
    idx_zero = (bit_idx == '0);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic: fields advance only at the end of a bit period
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (accept) next_state = START;
      START:  if (bit_end) next_state = PORT;
      PORT:   if (bit_end && idx_zero) next_state = COUNT;
      COUNT:  if (bit_end && idx_zero) next_state = (len_r == '0) ? FINISH : DATA;
      DATA:   if (bit_end && idx_zero) next_state = FINISH;
      FINISH: next_state = accept ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Tick counter, bit index and request shadow registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick      <= '0;
      bit_idx   <= '0;
      port_r    <= '0;
      len_r     <= '0;
      payload_r <= '0;
    end else if (accept) begin
      tick      <= '0;
      bit_idx   <= '0;
      port_r    <= port_sel;
      len_r     <= data_len;
      payload_r <= payload;
    end else if (busy) begin
      tick <= bit_end ? '0 : tick + TICK_ONE;
      if (bit_end) begin
        case (state)
          START:   bit_idx <= IDX_ONE;
          PORT:    bit_idx <= idx_zero ? IDX_MSB : bit_idx - IDX_ONE;
          COUNT:   bit_idx <= idx_zero ? len_r - IDX_ONE : bit_idx - IDX_ONE;
          DATA:    bit_idx <= bit_idx - IDX_ONE;
          default: bit_idx <= bit_idx;
        endcase
      end
    end
  end

  // Outputs: line level selected by current field and bit index, strobe in second half of bit
  always_comb begin
    len_mask   = IDX_ONE << bit_idx;
    pay_mask   = PAY_ONE << bit_idx;
    ready      = (state == IDLE) || (state == FINISH);
    done       = (state == FINISH);
    bit_strobe = busy && (tick >= TICK_HALF);
    ser_out    = 1'b1;
    case (state)
      START:   ser_out = 1'b0;
      PORT:    ser_out = port_r[bit_idx[0]];
      COUNT:   ser_out = |(len_r & len_mask);
      DATA:    ser_out = |(payload_r & pay_mask);
      default: ser_out = 1'b1;
    endcase
  end

endmodule
